// File: rtl/i2c_target_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : i2c_target_regfile                                        |
// | I2C target with a byte-wide register file. SCL/SDA are oversampled |
// | on clk_i, synchronised, glitch-filtered and edge-detected. Burst   |
// | writes/reads with pointer auto-increment, repeated START, pointer  |
// | range NACK and START/STOP abort from any state.                    |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module i2c_target_regfile #(
  parameter int NUM_REGS   = 16,
  parameter int FILTER_LEN = 3,
  localparam int PTR_W     = $clog2(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [6:0]            assigned_address_i,
  input  logic                  scl_i,
  inout  wire                   sda_io,
  output logic [8*NUM_REGS-1:0] regs_o,
  output logic                  wr_pulse_o,
  output logic [PTR_W-1:0]      wr_idx_o,
  output logic                  busy_o
);

  localparam int CNT_W = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_e;

  logic [1:0]       scl_sync_q, sda_sync_q;
  logic [CNT_W-1:0] scl_cnt_q, sda_cnt_q;
  logic             scl_f_q, sda_f_q, scl_prev_q, sda_prev_q;

  state_e           state_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             rw_q;
  logic             sda_oe_q;
  logic [PTR_W-1:0] ptr_q;
  logic [7:0]       regs_q [NUM_REGS];
  logic             wr_pulse_q;
  logic [PTR_W-1:0] wr_idx_q;
  logic             busy_q;

  logic             w_scl_rise, w_scl_fall, w_start, w_stop;
  logic             w_last_bit, w_ptr_ok;
  logic [7:0]       w_byte;
  logic [PTR_W-1:0] w_ptr_inc;

  // Two-flop synchronisers; preset high so reset looks like an idle bus
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_io};
    end
  end

  // Counter filters: level follows only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_f_q;
      sda_prev_q <= sda_f_q;
      if (scl_sync_q[1] == scl_f_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        scl_f_q   <= scl_sync_q[1];
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 1'b1;
      end
      if (sda_sync_q[1] == sda_f_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        sda_f_q   <= sda_sync_q[1];
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 1'b1;
      end
    end
  end

  assign w_scl_rise = scl_f_q & ~scl_prev_q;
  assign w_scl_fall = ~scl_f_q & scl_prev_q;
  assign w_start    = ~sda_f_q & sda_prev_q & scl_f_q;
  assign w_stop     = sda_f_q & ~sda_prev_q & scl_f_q;
  assign w_byte     = {shift_q[6:0], sda_f_q};
  assign w_last_bit = (bit_cnt_q == 3'd7);
  assign w_ptr_ok   = ({1'b0, w_byte} < 9'(NUM_REGS));
  assign w_ptr_inc  = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;

  // Protocol FSM. In the *_ACK states sda_oe_q doubles as the phase flag:
  // the first SCL fall starts driving ACK, the second one ends it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      ptr_q      <= '0;
      wr_pulse_q <= 1'b0;
      wr_idx_q   <= '0;
      busy_q     <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      wr_pulse_q <= 1'b0;
      if (w_start) begin
        busy_q    <= 1'b1;
        state_q   <= S_ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
      end else if (w_stop) begin
        busy_q    <= 1'b0;
        state_q   <= S_IDLE;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
      end else begin
        case (state_q)
          S_ADDR: if (w_scl_rise) begin
            shift_q   <= w_byte;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (w_last_bit) begin
              rw_q    <= w_byte[0];
              state_q <= (w_byte[7:1] == assigned_address_i && assigned_address_i != 7'd0)
                         ? S_ADDR_ACK : S_IGNORE;
            end
          end
          S_ADDR_ACK: if (w_scl_fall) begin
            bit_cnt_q <= '0;
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else if (rw_q) begin
              // First read bit goes out on the same fall that ends the ACK
              state_q  <= S_RDATA;
              shift_q  <= regs_q[ptr_q];
              sda_oe_q <= ~regs_q[ptr_q][7];
            end else begin
              state_q  <= S_PTR;
              sda_oe_q <= 1'b0;
            end
          end
          S_PTR: if (w_scl_rise) begin
            shift_q   <= w_byte;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (w_last_bit) begin
              if (w_ptr_ok) begin
                ptr_q   <= w_byte[PTR_W-1:0];
                state_q <= S_PTR_ACK;
              end else begin
                state_q <= S_IGNORE;
              end
            end
          end
          S_PTR_ACK: if (w_scl_fall) begin
            bit_cnt_q <= '0;
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= S_WDATA;
            end
          end
          S_WDATA: if (w_scl_rise) begin
            shift_q   <= w_byte;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (w_last_bit) begin
              regs_q[ptr_q] <= w_byte;
              wr_pulse_q    <= 1'b1;
              wr_idx_q      <= ptr_q;
              state_q       <= S_WDATA_ACK;
            end
          end
          S_WDATA_ACK: if (w_scl_fall) begin
            bit_cnt_q <= '0;
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else begin
              sda_oe_q <= 1'b0;
              ptr_q    <= w_ptr_inc;
              state_q  <= S_WDATA;
            end
          end
          S_RDATA: begin
            if (w_scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (w_last_bit) state_q <= S_RDATA_ACK;
            end else if (w_scl_fall) begin
              // bit_cnt_q == 0 only when re-entered after a controller ACK
              if (bit_cnt_q == 3'd0) begin
                sda_oe_q <= ~shift_q[7];
              end else begin
                shift_q  <= {shift_q[6:0], 1'b0};
                sda_oe_q <= ~shift_q[6];
              end
            end
          end
          S_RDATA_ACK: begin
            if (w_scl_fall) begin
              sda_oe_q <= 1'b0;
            end else if (w_scl_rise) begin
              // Every byte read advances the pointer, ACKed or not
              ptr_q     <= w_ptr_inc;
              bit_cnt_q <= '0;
              if (!sda_f_q) begin
                shift_q <= regs_q[w_ptr_inc];
                state_q <= S_RDATA;
              end else begin
                state_q <= S_IGNORE;
              end
            end
          end
          S_IDLE, S_IGNORE: sda_oe_q <= 1'b0;
          default: begin
            state_q  <= S_IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    assign regs_o[8*k +: 8] = regs_q[k];
  end

  assign sda_io     = sda_oe_q ? 1'b0 : 1'bz;
  assign wr_pulse_o = wr_pulse_q;
  assign wr_idx_o   = wr_idx_q;
  assign busy_o     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_i2c_target_regfile                                     |
// | Bench for i2c_target_regfile: bit-banged I2C controller, directed  |
// | scenarios plus random transactions against a transaction-level     |
// | register-file model.                                               |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module tb_i2c_target_regfile;
  localparam int NUM_REGS   = 16;
  localparam int FILTER_LEN = 3;
  localparam int PTR_W      = 4;
  localparam int Q          = 8;     // clk cycles per quarter SCL period
  localparam logic [6:0] MY_ADDR = 7'h40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] addr_cfg = MY_ADDR;
  logic scl = 1'b1;
  logic sda_low = 1'b0;
  wire  sda_w;
  logic [8*NUM_REGS-1:0] regs;
  logic wr_pulse;
  logic [PTR_W-1:0] wr_idx;
  logic busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl_regs [NUM_REGS];
  int mdl_ptr;
  int exp_wr[$];
  int got_wr[$];
  logic [7:0] wdata[$];

  assign sda_w = sda_low ? 1'b0 : 1'bz;
  pullup (sda_w);

  always #5 clk = ~clk;

  i2c_target_regfile #(.NUM_REGS(NUM_REGS), .FILTER_LEN(FILTER_LEN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .assigned_address_i(addr_cfg), .scl_i(scl),
    .sda_io(sda_w), .regs_o(regs), .wr_pulse_o(wr_pulse), .wr_idx_o(wr_idx), .busy_o(busy)
  );

  // Record every write strobe the target issues
  always @(negedge clk) if (wr_pulse) got_wr.push_back(int'(wr_idx));

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit sda_hi();
    return sda_w !== 1'b0;
  endfunction

  function automatic logic [127:0] mdl_flat();
    logic [127:0] v;
    for (int k = 0; k < NUM_REGS; k++) v[8*k +: 8] = mdl_regs[k];
    return v;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bus primitives: every bit task starts and ends just after SCL falls
  task automatic bus_start();
    clks(Q); sda_low = 1'b0; clks(Q); scl = 1'b1; clks(2*Q);
    sda_low = 1'b1; clks(2*Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    clks(Q); sda_low = 1'b1; clks(Q); scl = 1'b1; clks(2*Q);
    sda_low = 1'b0; clks(2*Q);
  endtask

  task automatic put_bit(input logic b, input bit glitch);
    clks(Q); sda_low = ~b; clks(Q); scl = 1'b1;
    if (glitch) begin
      clks(Q); scl = 1'b0; clks(1); scl = 1'b1; clks(Q-1);
    end else begin
      clks(2*Q);
    end
    scl = 1'b0;
  endtask

  task automatic get_bit(output logic b);
    clks(Q); sda_low = 1'b0; clks(Q); scl = 1'b1; clks(Q);
    b = sda_hi(); clks(Q); scl = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) put_bit(d[i], 1'b0);
    get_bit(ack_n);
  endtask

  task automatic get_byte(input logic ack_n, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) get_bit(d[i]);
    put_bit(ack_n, 1'b0);
  endtask

  // Write transaction: address, pointer, then every byte queued in wdata
  task automatic do_write(input logic [6:0] a, input logic [7:0] p, input bit do_stop, input string tag);
    logic ack_n;
    bit a_ok, p_ok;
    a_ok = (a == addr_cfg) && (addr_cfg != 7'd0);
    p_ok = a_ok && (p < NUM_REGS);
    bus_start();
    check({tag, " busy"}, busy, 1'b1);
    put_byte({a, 1'b0}, ack_n);
    check({tag, " addr ack"}, ack_n, !a_ok);
    put_byte(p, ack_n);
    check({tag, " ptr ack"}, ack_n, !p_ok);
    if (p_ok) mdl_ptr = int'(p);
    foreach (wdata[i]) begin
      put_byte(wdata[i], ack_n);
      check({tag, $sformatf(" data%0d ack", i)}, ack_n, !p_ok);
      if (p_ok) begin
        mdl_regs[mdl_ptr] = wdata[i];
        exp_wr.push_back(mdl_ptr);
        mdl_ptr = (mdl_ptr + 1) % NUM_REGS;
      end
    end
    if (do_stop) bus_stop();
  endtask

  // Read transaction: n bytes, ACK all but the last; STOP afterwards
  task automatic do_read(input logic [6:0] a, input int n, input string tag);
    logic ack_n;
    logic [7:0] d;
    bit a_ok;
    a_ok = (a == addr_cfg) && (addr_cfg != 7'd0);
    bus_start();
    put_byte({a, 1'b1}, ack_n);
    check({tag, " rd addr ack"}, ack_n, !a_ok);
    if (a_ok) begin
      for (int i = 0; i < n; i++) begin
        get_byte(i == n - 1, d);
        check({tag, $sformatf(" rd byte%0d", i)}, d, mdl_regs[mdl_ptr]);
        mdl_ptr = (mdl_ptr + 1) % NUM_REGS;
      end
    end
    clks(Q);
    check({tag, " sda released"}, sda_hi(), 1'b1);
    bus_stop();
  endtask

  task automatic check_regs(input string tag);
    check({tag, " regs"}, regs, mdl_flat());
  endtask

  task automatic check_wr(input string tag);
    check({tag, " wr count"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      check({tag, $sformatf(" wr idx%0d", i)}, got_wr[i], exp_wr[i]);
    got_wr.delete();
    exp_wr.delete();
  endtask

  initial begin
    logic ack_n;
    logic [7:0] p;
    logic [6:0] a;
    int n, kind;

    for (int k = 0; k < NUM_REGS; k++) mdl_regs[k] = 8'h00;
    mdl_ptr = 0;

    // Reset state
    clks(5);
    check("reset regs", regs, '0);
    check("reset wr_pulse", wr_pulse, 1'b0);
    check("reset wr_idx", wr_idx, '0);
    check("reset busy", busy, 1'b0);
    check("reset sda", sda_hi(), 1'b1);
    rst_n = 1'b1;
    clks(4*Q);

    // Basic burst write
    wdata = '{8'hA5, 8'h5A};
    do_write(MY_ADDR, 8'h03, 1'b1, "t1");
    check("t1 reg3", regs[8*3 +: 8], 8'hA5);
    check("t1 reg4", regs[8*4 +: 8], 8'h5A);
    check("t1 busy after stop", busy, 1'b0);
    check_regs("t1"); check_wr("t1");

    // Pointer wrap, then out-of-range pointer NACK leaves ptr at 1
    wdata = '{8'h11, 8'h22};
    do_write(MY_ADDR, 8'h0F, 1'b1, "t2");
    check("t2 reg15", regs[8*15 +: 8], 8'h11);
    check("t2 reg0", regs[8*0 +: 8], 8'h22);
    wdata = '{8'h77};
    do_write(MY_ADDR, 8'h10, 1'b1, "t2 nack");
    check_regs("t2"); check_wr("t2");
    wdata = '{8'h9E};
    do_write(MY_ADDR, 8'h01, 1'b1, "t2 mark");
    wdata = '{};
    do_write(MY_ADDR, 8'h10, 1'b1, "t2 nack2");
    do_read(MY_ADDR, 1, "t2 ptr kept");
    check_wr("t2b");

    // Combined format: pointer write, repeated START, 3-byte read
    wdata = '{8'h66};
    do_write(MY_ADDR, 8'h06, 1'b1, "t3 prep");
    wdata = '{};
    do_write(MY_ADDR, 8'h03, 1'b0, "t3");
    do_read(MY_ADDR, 3, "t3");
    do_read(MY_ADDR, 1, "t3 ptr6");
    check_wr("t3");

    // Foreign address: ignored but bus reported busy until STOP
    wdata = '{8'h99};
    do_write(7'h41, 8'h02, 1'b0, "t4");
    check("t4 busy mid", busy, 1'b1);
    bus_stop();
    check("t4 busy after stop", busy, 1'b0);
    check_regs("t4"); check_wr("t4");
    wdata = '{8'h3C};
    do_write(MY_ADDR, 8'h02, 1'b1, "t4 next");
    check_regs("t4 next"); check_wr("t4 next");

    // Address zero is never acknowledged, even when assigned
    addr_cfg = 7'h00;
    wdata = '{8'hEE};
    do_write(7'h00, 8'h05, 1'b1, "t5 zero");
    addr_cfg = MY_ADDR;
    check_regs("t5"); check_wr("t5");

    // Mid-byte STOP discards the partial byte
    bus_start();
    put_byte({MY_ADDR, 1'b0}, ack_n);
    check("t6 addr ack", ack_n, 1'b0);
    put_byte(8'h07, ack_n);
    check("t6 ptr ack", ack_n, 1'b0);
    mdl_ptr = 7;
    put_bit(1'b1, 1'b0); put_bit(1'b0, 1'b0); put_bit(1'b1, 1'b0); put_bit(1'b0, 1'b0);
    bus_stop();
    check("t6 sda released", sda_hi(), 1'b1);
    check("t6 busy", busy, 1'b0);
    check_regs("t6"); check_wr("t6");
    do_read(MY_ADDR, 1, "t6 ptr");

    // One-clock SCL glitch during a data bit is filtered out
    bus_start();
    put_byte({MY_ADDR, 1'b0}, ack_n);
    put_byte(8'h08, ack_n);
    for (int i = 7; i >= 0; i--) put_bit(((8'hB6 >> i) & 1) != 0, i == 3);
    get_bit(ack_n);
    check("t7 glitch ack", ack_n, 1'b0);
    mdl_regs[8] = 8'hB6; exp_wr.push_back(8); mdl_ptr = 9;
    bus_stop();
    check_regs("t7"); check_wr("t7");

    // Random traffic against the model
    for (int it = 0; it < 16; it++) begin
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 7) == 0) ? 7'h23 : MY_ADDR;
      p = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, NUM_REGS-1));
      n = $urandom_range(1, 4);
      wdata.delete();
      if (kind == 0) begin
        for (int i = 0; i < n; i++) wdata.push_back(8'($urandom));
        do_write(a, p, 1'b1, "rnd wr");
      end else if (kind == 1) begin
        do_write(a, p, 1'b0, "rnd ptr");
        do_read(a, n, "rnd cmb");
      end else begin
        do_read(a, n, "rnd rd");
      end
      check_regs("rnd"); check_wr("rnd");
    end

    // Reset while the target drives ACK low
    bus_start();
    for (int i = 7; i >= 0; i--) put_bit(((8'h80 >> i) & 1) != 0, 1'b0);
    sda_low = 1'b0;
    clks(Q);
    check("t8 ack driven", sda_hi(), 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("t8 sda async release", sda_hi(), 1'b1);
    check("t8 regs cleared", regs, '0);
    check("t8 busy", busy, 1'b0);
    for (int k = 0; k < NUM_REGS; k++) mdl_regs[k] = 8'h00;
    mdl_ptr = 0;
    got_wr.delete(); exp_wr.delete();
    clks(Q); scl = 1'b1; clks(4);
    rst_n = 1'b1;
    clks(4*Q);
    wdata = '{8'h42};
    do_write(MY_ADDR, 8'h01, 1'b1, "t8 after");
    check_regs("t8 after"); check_wr("t8 after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
